// File: rtl/dvbs2_frame_feeder.sv
// dvbs2_frame_feeder: feeds TS bytes into the DVB-S2 baseband input one bit per enabled
// cycle, MSB first, tagging packet (UPL_BITS) and BB-frame (DFL_BITS) boundaries.
// Frames start only when the transmitter raises next_frame; packets may straddle frames.
//
// Ports:
//   clk, reset_n            system clock, asynchronous active-low reset
//   enable                  clock enable from the transmitter; low freezes all state
//   s_data/s_valid/s_ready  byte stream from the buffer (s_ready is combinational)
//   next_frame              transmitter ready for a new BB frame (level)
//   pkt_out                 registered {bit, pktStart, pktEnd, pktValid, frameStart, frameEnd}
//   busy                    high while a frame is being sent
//   frame_cnt               completed frames, wrapping
//   urun_cnt                underrun events, saturating
//   sync_err                (SYNC_CHECK_EN only) one-cycle pulse per dropped non-sync byte
//
// Optional feature macro: SYNC_CHECK_EN (packet-start sync byte check).
//
// An underrun event is a stall in SEND (no bit available) while the source has no byte
// to offer. The single fetch cycle after entering SEND with an empty shift register is
// not an underrun, since a byte is being accepted in that very cycle.
module dvbs2_frame_feeder #(
  parameter int unsigned UPL_BITS  = 1504,
  parameter int unsigned DFL_BITS  = 42960,
  parameter logic [7:0]  SYNC_BYTE = 8'h47
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic [7:0]  s_data,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic        next_frame,
  output logic [5:0]  pkt_out,
  output logic        busy,
  output logic [15:0] frame_cnt,
  output logic [15:0] urun_cnt
`ifdef SYNC_CHECK_EN
  ,
  output logic        sync_err
`endif
);

  localparam int unsigned PW = $clog2(UPL_BITS);
  localparam int unsigned FW = $clog2(DFL_BITS);
  localparam logic [PW-1:0] PKT_LAST = PW'(UPL_BITS - 1);
  localparam logic [FW-1:0] FRM_LAST = FW'(DFL_BITS - 1);

  typedef enum logic {WAIT_NF = 1'b0, SEND = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   pkt_bit_q, pkt_bit_d;
  logic [FW-1:0]   frm_bit_q, frm_bit_d;
  logic [7:0]      sr_q, sr_d;
  logic            have_q, have_d;
  logic [2:0]      idx_q, idx_d;
  logic            urun_act_q, urun_act_d;
  logic [5:0]      pkt_d;
  logic [15:0]     frame_cnt_d, urun_cnt_d;
  logic            take, load;
`ifdef SYNC_CHECK_EN
  logic            sync_err_d;
`else
  logic            unused_sync;
  assign unused_sync = ^SYNC_BYTE;
`endif

  // Accept a byte when the register is empty or its last bit leaves this cycle.
  assign s_ready = enable & (state_q == SEND) & (~have_q | (idx_q == 3'd7));
  assign take    = s_valid & s_ready;
  assign busy    = (state_q == SEND);

  // Next-state, bit emission and counter updates.
  always_comb begin
    state_d     = state_q;
    pkt_bit_d   = pkt_bit_q;
    frm_bit_d   = frm_bit_q;
    sr_d        = sr_q;
    have_d      = have_q;
    idx_d       = idx_q;
    urun_act_d  = urun_act_q;
    pkt_d       = 6'b0;
    frame_cnt_d = frame_cnt;
    urun_cnt_d  = urun_cnt;
    load        = 1'b0;
`ifdef SYNC_CHECK_EN
    sync_err_d  = 1'b0;
`endif
    if (enable) begin
      case (state_q)
        WAIT_NF: begin
          urun_act_d = 1'b0;
          if (next_frame) state_d = SEND;
        end
        SEND: begin
          if (have_q) begin
            pkt_d = {sr_q[7], (pkt_bit_q == '0), (pkt_bit_q == PKT_LAST), 1'b1,
                     (frm_bit_q == '0), (frm_bit_q == FRM_LAST)};
            pkt_bit_d  = (pkt_bit_q == PKT_LAST) ? '0 : pkt_bit_q + PW'(1);
            sr_d       = {sr_q[6:0], 1'b0};
            idx_d      = idx_q + 3'd1;
            urun_act_d = 1'b0;
            if (idx_q == 3'd7) have_d = 1'b0;
            if (frm_bit_q == FRM_LAST) begin
              frm_bit_d   = '0;
              frame_cnt_d = frame_cnt + 16'd1;
              state_d     = WAIT_NF;
            end else begin
              frm_bit_d = frm_bit_q + FW'(1);
            end
          end else if (!s_valid && !urun_act_q) begin
            urun_act_d = 1'b1;
            if (urun_cnt != 16'hFFFF) urun_cnt_d = urun_cnt + 16'd1;
          end
          // pkt_bit_d is the packet position of the first bit of the incoming byte.
          if (take) begin
            load = 1'b1;
`ifdef SYNC_CHECK_EN
            if ((pkt_bit_d == '0) && (s_data != SYNC_BYTE)) begin
              load       = 1'b0;
              sync_err_d = 1'b1;
            end
`endif
            if (load) begin
              sr_d   = s_data;
              have_d = 1'b1;
              idx_d  = 3'd0;
            end
          end
        end
        default: state_d = WAIT_NF;
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= WAIT_NF;
      pkt_bit_q  <= '0;
      frm_bit_q  <= '0;
      sr_q       <= 8'h00;
      have_q     <= 1'b0;
      idx_q      <= 3'd0;
      urun_act_q <= 1'b0;
      pkt_out    <= 6'b0;
      frame_cnt  <= 16'h0000;
      urun_cnt   <= 16'h0000;
`ifdef SYNC_CHECK_EN
      sync_err   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      pkt_bit_q  <= pkt_bit_d;
      frm_bit_q  <= frm_bit_d;
      sr_q       <= sr_d;
      have_q     <= have_d;
      idx_q      <= idx_d;
      urun_act_q <= urun_act_d;
      pkt_out    <= pkt_d;
      frame_cnt  <= frame_cnt_d;
      urun_cnt   <= urun_cnt_d;
`ifdef SYNC_CHECK_EN
      sync_err   <= sync_err_d;
`endif
    end
  end

endmodule

// File: tb/tb_dvbs2_frame_feeder.sv
// Testbench for dvbs2_frame_feeder with UPL_BITS=16, DFL_BITS=40.
// Reference model: every accepted byte is appended to a queue; the k-th emitted bit since
// reset must be bit (7 - k%8) of byte k/8, with packet/frame flags derived from k modulo
// the packet and frame lengths, and frame_cnt equal to k/DFL.
module tb_dvbs2_frame_feeder;

  localparam int unsigned UPL = 16;
  localparam int unsigned DFL = 40;
  localparam int unsigned BPP = UPL / 8;

  logic        clk;
  logic        reset_n;
  logic        enable;
  logic [7:0]  s_data;
  logic        s_valid;
  logic        s_ready;
  logic        next_frame;
  logic [5:0]  pkt_out;
  logic        busy;
  logic [15:0] frame_cnt;
  logic [15:0] urun_cnt;
`ifdef SYNC_CHECK_EN
  logic        sync_err;
`endif

  dvbs2_frame_feeder #(.UPL_BITS(UPL), .DFL_BITS(DFL), .SYNC_BYTE(8'h47)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .enable     (enable),
    .s_data     (s_data),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .next_frame (next_frame),
    .pkt_out    (pkt_out),
    .busy       (busy),
    .frame_cnt  (frame_cnt),
    .urun_cnt   (urun_cnt)
`ifdef SYNC_CHECK_EN
    ,
    .sync_err   (sync_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         vecs = 0;
  int         miscompares = 0;
  logic [7:0] byte_q[$];
  int         k = 0;
  int         cyc = 0;
  bit         prev_fe = 1'b0;
  bit         fe_seen = 1'b0;
  int         sync_pulses = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [5:0] exp_vec(input int kk);
    logic [7:0] b;
    logic       bt;
    if (kk / 8 < byte_q.size()) b = byte_q[kk / 8];
    else b = 8'hxx;
    bt = b[3'(7 - (kk % 8))];
    return {bt, (kk % UPL == 0), (kk % UPL == UPL - 1), 1'b1,
            (kk % DFL == 0), (kk % DFL == DFL - 1)};
  endfunction

  // Byte offered next: sync byte at packet starts, A5 as the second byte, else random.
  function automatic logic [7:0] gen_byte(input bit rnd);
    int pos;
    pos = byte_q.size();
    if (pos % BPP == 0) begin
      if (rnd && ($urandom_range(1) == 0)) return 8'($urandom);
      return 8'h47;
    end
    if (pos == 1 && !rnd) return 8'hA5;
    return 8'($urandom);
  endfunction

  // One clock: called at posedge+1 with inputs already driven; returns at next posedge+1.
  task automatic tick();
    bit         acc, en, drop;
    logic [5:0] e;
    e = 6'b0;
    #3;
    en   = enable;
    acc  = reset_n && s_valid && s_ready;
    drop = 1'b0;
`ifdef SYNC_CHECK_EN
    drop = acc && (byte_q.size() % BPP == 0) && (s_data != 8'h47);
`endif
    if (acc && !drop) byte_q.push_back(s_data);
    @(posedge clk);
    #1;
    cyc++;
    if (pkt_out[2] === 1'b1) begin
      e = exp_vec(k);
      chk($sformatf("bit%0d", k), 32'(pkt_out), 32'(e));
      if (e[0]) fe_seen = 1'b1;
      k++;
    end else begin
      chk("idle_zero", 32'(pkt_out), 32'd0);
    end
    if (!en) chk("frozen_idle", 32'(pkt_out[2]), 32'd0);
    if (prev_fe) chk("wait_after_fe", 32'(pkt_out[2]), 32'd0);
    prev_fe = (pkt_out[2] === 1'b1) && e[0];
    chk("frame_cnt", 32'(frame_cnt), 32'(16'(k / DFL)));
`ifdef SYNC_CHECK_EN
    chk("sync_err", 32'(sync_err), 32'(drop));
    if (sync_err === 1'b1) sync_pulses++;
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int first, n, zeros, en_cnt, v_cnt;
    logic [15:0] last_urun;
    reset_n = 1'b0; enable = 1'b0; s_valid = 1'b0; next_frame = 1'b0; s_data = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pkt_out", 32'(pkt_out), 32'd0);
    chk("rst_s_ready", 32'(s_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    chk("rst_urun_cnt", 32'(urun_cnt), 32'd0);

    // Frame 1: continuous bytes 47, A5, ...
    reset_n = 1'b1; enable = 1'b1; next_frame = 1'b1; s_valid = 1'b1;
    first = -1; n = 0; fe_seen = 1'b0;
    while (!fe_seen && n < 200) begin
      s_data = gen_byte(1'b0); tick();
      if (pkt_out[2] === 1'b1 && first < 0) first = cyc;
      n++;
    end
    chk("f1_done", 32'(fe_seen), 32'd1);
    chk("f1_latency", 32'(first), 32'd3);
    chk("f1_span", 32'(cyc - first), 32'd39);
    chk("f1_busy", 32'(busy), 32'd0);
    chk("f1_cnt", 32'(frame_cnt), 32'd1);
    chk("f1_urun", 32'(urun_cnt), 32'd0);

    // Pacing: no frame while next_frame is low.
    next_frame = 1'b0;
    for (int i = 0; i < 10; i++) begin
      s_data = gen_byte(1'b0); tick();
      chk("pace_idle", 32'(pkt_out[2]), 32'd0);
      chk("pace_busy", 32'(busy), 32'd0);
    end

    // Frame 2: straddled packet, then a 5-cycle underrun at a byte boundary.
    next_frame = 1'b1; n = 0;
    while (k < 63 && n < 200) begin
      s_data = gen_byte(1'b0); tick();
      if (k == 41) chk("straddle_fs_ps", 32'({pkt_out[4], pkt_out[1]}), 32'd1);
      if (k == 48) chk("straddle_pe", 32'(pkt_out[3]), 32'd1);
      n++;
    end
    chk("k_at_63", 32'(k), 32'd63);
    s_valid = 1'b0; zeros = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (pkt_out[2] !== 1'b1) zeros++;
    end
    s_valid = 1'b1; n = 0;
    do begin
      s_data = gen_byte(1'b0); tick();
      if (pkt_out[2] !== 1'b1) zeros++;
      n++;
    end while (pkt_out[2] !== 1'b1 && n < 20);
    chk("urun_gap", 32'(zeros), 32'd5);
    chk("urun_cnt", 32'(urun_cnt), 32'd1);
    chk("resume_k", 32'(k), 32'd65);
    fe_seen = 1'b0; n = 0;
    while (!fe_seen && n < 200) begin
      s_data = gen_byte(1'b0); tick(); n++;
    end
    chk("f2_cnt", 32'(frame_cnt), 32'd2);
    chk("f2_busy", 32'(busy), 32'd0);

    // Frame 3 with enable toggling: one bit per enabled cycle.
    n = 0;
    do begin
      s_data = gen_byte(1'b0); tick(); n++;
    end while (pkt_out[2] !== 1'b1 && n < 20);
    chk("f3_start", 32'(k), 32'd81);
    en_cnt = 0; v_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      enable = (i % 2 == 1);
      s_data = gen_byte(1'b0); tick();
      if (enable) en_cnt++;
      if (pkt_out[2] === 1'b1) v_cnt++;
    end
    chk("en_bits", 32'(v_cnt), 32'(en_cnt));
    chk("en_urun", 32'(urun_cnt), 32'd1);

    // Randomised traffic.
    last_urun = urun_cnt;
    for (int i = 0; i < 2000; i++) begin
      enable     = ($urandom_range(3) != 0);
      s_valid    = ($urandom_range(9) < 7);
      next_frame = 1'($urandom_range(1));
      s_data     = gen_byte(1'b1);
      tick();
      chk("urun_mono", 32'(urun_cnt >= last_urun), 32'd1);
      last_urun = urun_cnt;
    end
    chk("rand_progress", 32'(k > 200), 32'd1);

    // Asynchronous reset in the middle of a frame.
    enable = 1'b1; s_valid = 1'b1; next_frame = 1'b1; n = 0;
    do begin
      s_data = gen_byte(1'b0); tick(); n++;
    end while (pkt_out[2] !== 1'b1 && n < 50);
    chk("pre_rst_valid", 32'(pkt_out[2]), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_pkt_out", 32'(pkt_out), 32'd0);
    chk("arst_s_ready", 32'(s_ready), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_frame_cnt", 32'(frame_cnt), 32'd0);
    chk("arst_urun_cnt", 32'(urun_cnt), 32'd0);
    byte_q.delete(); k = 0; prev_fe = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1; n = 0;
    do begin
      s_data = gen_byte(1'b0); tick(); n++;
    end while (pkt_out[2] !== 1'b1 && n < 20);
    chk("post_rst_start", 32'({pkt_out[4], pkt_out[1]}), 32'd3);

`ifdef SYNC_CHECK_EN
    // Non-sync byte at a packet start is dropped with one sync_err pulse.
    reset_n = 1'b0;
    #1;
    byte_q.delete(); k = 0; prev_fe = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1; sync_pulses = 0;
    s_data = 8'h12; tick();
    s_data = 8'h12; tick();
    n = 0;
    do begin
      s_data = 8'h47; tick(); n++;
    end while (pkt_out[2] !== 1'b1 && n < 10);
    chk("sync_pulses", 32'(sync_pulses), 32'd1);
    chk("sync_pkt_start", 32'(pkt_out[4]), 32'd1);
    chk("sync_first_bit", 32'(pkt_out[5]), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
    $finish;
  end

endmodule
